// File: rtl/slv_guard_cfg_seq.sv
// Configuration sequencer: writes guard budget registers, then the enable register, over a
// simple register bus. Define SLV_GUARD_CFG_READBACK_EN to verify every write with a read-back.
module slv_guard_cfg_seq #(
    parameter int unsigned          AddrWidth  = 32,
    parameter int unsigned          DataWidth  = 32,
    parameter int unsigned          NumBudgets = 8,
    parameter logic [AddrWidth-1:0] BudgetBase = AddrWidth'(32'h4),
    parameter logic [AddrWidth-1:0] EnableAddr = AddrWidth'(32'h0),
    parameter logic [DataWidth-1:0] EnableVal  = DataWidth'(32'h100),
    parameter int unsigned          MaxRetries = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    input  logic [NumBudgets*DataWidth-1:0] budgets_i,
    input  logic                            rst_req_i,
    output logic [AddrWidth-1:0]            reg_addr_o,
    output logic [DataWidth-1:0]            reg_wdata_o,
    output logic [DataWidth/8-1:0]          reg_wstrb_o,
    output logic                            reg_write_o,
    output logic                            reg_valid_o,
    input  logic                            reg_ready_i,
    input  logic                            reg_error_i,
    input  logic [DataWidth-1:0]            reg_rdata_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o
);

    localparam int unsigned IdxW   = $clog2(NumBudgets + 1);
    localparam int unsigned BIdxW  = (NumBudgets > 1) ? $clog2(NumBudgets) : 1;
    localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
    // Index value NumBudgets stands for the enable register access.
    localparam logic [IdxW-1:0]   EnIdx     = IdxW'(NumBudgets);
    localparam logic [IdxW-1:0]   LastIdx   = IdxW'(NumBudgets - 1);
    localparam logic [RetryW-1:0] MaxRetryC = RetryW'(MaxRetries);

    typedef enum logic [2:0] {
        StIdle,
        StWrBudget,
        StWrEnable,
        StDone,
`ifdef SLV_GUARD_CFG_READBACK_EN
        StRdCheck,
`endif
        StError
    } state_e;

    state_e                 state_q, state_d;
    logic                   valid_q, valid_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [RetryW-1:0]      retry_q, retry_d;
    logic [DataWidth-1:0]   budget_q [NumBudgets];
    logic [DataWidth-1:0]   budget_d [NumBudgets];

    logic                   is_enable;
    logic                   retry_ok;
    logic                   is_read;
    logic [IdxW-1:0]        adv_idx;
    state_e                 adv_state;
    logic [AddrWidth-1:0]   cur_addr;
    logic [DataWidth-1:0]   cur_data;

    assign is_enable = (idx_q == EnIdx);
    assign retry_ok  = (retry_q < MaxRetryC);
    assign adv_idx   = is_enable ? idx_q : idx_q + IdxW'(1);
    assign adv_state = is_enable ? StDone : ((idx_q == LastIdx) ? StWrEnable : StWrBudget);
    assign cur_addr  = is_enable ? EnableAddr : BudgetBase + (AddrWidth'(idx_q) << 2);
    assign cur_data  = is_enable ? EnableVal : budget_q[idx_q[BIdxW-1:0]];

`ifdef SLV_GUARD_CFG_READBACK_EN
    assign is_read = (state_q == StRdCheck);
`else
    logic unused_rdata;
    assign is_read      = 1'b0;
    assign unused_rdata = ^reg_rdata_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            idx_q   <= '0;
            retry_q <= '0;
            for (int k = 0; k < NumBudgets; k++) budget_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            budget_q <= budget_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        retry_d  = retry_q;
        budget_d = budget_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_i) begin
                    for (int k = 0; k < NumBudgets; k++) begin
                        budget_d[k] = budgets_i[k*DataWidth +: DataWidth];
                    end
                    idx_d   = '0;
                    retry_d = '0;
                    valid_d = 1'b0;
                    state_d = StWrBudget;
                end else if (state_q == StDone && rst_req_i) begin
                    // Guard was reset: replay the stored configuration.
                    idx_d   = '0;
                    retry_d = '0;
                    valid_d = 1'b0;
                    state_d = StWrBudget;
                end
            end
            StWrBudget, StWrEnable: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (reg_ready_i) begin
                    valid_d = 1'b0;
                    if (reg_error_i) begin
                        if (retry_ok) retry_d = retry_q + RetryW'(1);
                        else          state_d = StError;
                    end else begin
`ifdef SLV_GUARD_CFG_READBACK_EN
                        state_d = StRdCheck;
`else
                        retry_d = '0;
                        idx_d   = adv_idx;
                        state_d = adv_state;
`endif
                    end
                end
            end
`ifdef SLV_GUARD_CFG_READBACK_EN
            StRdCheck: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (reg_ready_i) begin
                    valid_d = 1'b0;
                    if (reg_error_i || reg_rdata_i != cur_data) begin
                        if (retry_ok) begin
                            retry_d = retry_q + RetryW'(1);
                            state_d = is_enable ? StWrEnable : StWrBudget;
                        end else begin
                            state_d = StError;
                        end
                    end else begin
                        retry_d = '0;
                        idx_d   = adv_idx;
                        state_d = adv_state;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // All request fields come from registers only, so they hold while ready is low.
    assign reg_valid_o = valid_q;
    assign reg_write_o = valid_q && !is_read;
    assign reg_addr_o  = valid_q ? cur_addr : '0;
    assign reg_wdata_o = (valid_q && !is_read) ? cur_data : '0;
    assign reg_wstrb_o = (valid_q && !is_read) ? '1 : '0;

    assign busy_o = (state_q == StWrBudget) || (state_q == StWrEnable) || is_read;
    assign done_o = (state_q == StDone);
    assign err_o  = (state_q == StError);

endmodule

// File: doc/slv_guard_cfg_seq.md
SLV_GUARD_CFG_SEQ -- requirements
Module: slv_guard_cfg_seq

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, register-bus address width.
REQ-002 SHALL have parameter DataWidth, default 32, register-bus data width.
REQ-003 SHALL have parameter NumBudgets, default 8, number of budget registers programmed.
REQ-004 SHALL have parameter BudgetBase, default 32'h4, address of first budget register; stride 4.
REQ-005 SHALL have parameter EnableAddr / EnableVal, default 32'h0 / 32'h100, guard enable register and value.
REQ-006 SHALL have parameter MaxRetries, default 2, retries per access after error response.
REQ-007 clk_i  in  1  clock; single clock domain.
REQ-008 rst_ni  in  1  asynchronous active-low reset.
REQ-009 start_i  in  1  one-cycle pulse starting the configuration sequence.
REQ-010 budgets_i  in  NumBudgets*DataWidth  budget values, entry k at bits [k*DataWidth +: DataWidth].
REQ-011 rst_req_i  in  1  reset request from the guard; level.
REQ-012 reg_addr_o / reg_wdata_o / reg_wstrb_o / reg_write_o / reg_valid_o  out  AddrWidth / DataWidth / DataWidth/8 / 1 / 1  register-bus request.
REQ-013 reg_ready_i / reg_error_i / reg_rdata_i  in  1 / 1 / DataWidth  register-bus response.
REQ-014 busy_o  out  1  sequence in progress.
REQ-015 done_o  out  1  guard configured and enabled (level).
REQ-016 err_o  out  1  sequence aborted (sticky until next start_i).

Function
REQ-017 States: IDLE, WR_BUDGET, WR_ENABLE, DONE, ERROR (plus RD_CHECK, see Configuration).
REQ-018 IDLE, DONE or ERROR + start_i: capture budgets_i into internal registers, clear index, retries, err_o; go WR_BUDGET next cycle.
REQ-019 WR_BUDGET: reg_valid_o=1, reg_write_o=1, reg_wstrb_o all ones, reg_addr_o=BudgetBase+4*index, reg_wdata_o=captured budget[index].
REQ-020 Request fields SHALL be stable while reg_valid_o=1 and reg_ready_i=0; no combinational path from reg_ready_i to request outputs.
REQ-021 Handshake completes on reg_valid_o && reg_ready_i; reg_valid_o deasserts at least one cycle between accesses.
REQ-022 Completed budget write without error: index+1; after index NumBudgets-1 go WR_ENABLE.
REQ-023 WR_ENABLE: write EnableVal to EnableAddr; on success go DONE, done_o=1.
REQ-024 Completion with reg_error_i=1: reissue same access if retries<MaxRetries (retries+1), else go ERROR, err_o=1; retries clear on each successful access.
REQ-025 Enable write is always last: guard is never enabled with partially programmed budgets.
REQ-026 DONE + rst_req_i=1: done_o=0, restart at WR_BUDGET with stored budgets (re-arm after guard reset); rst_req_i ignored in other states.
REQ-027 start_i while busy_o=1 SHALL be ignored.
REQ-028 busy_o=1 exactly in WR_BUDGET, WR_ENABLE, RD_CHECK.
REQ-029 Latency with zero-wait ready: NumBudgets+1 accesses, 2 cycles each, done_o high 2*(NumBudgets+1)+1 cycles after start_i.

Reset
REQ-030 rst_ni low SHALL force IDLE, all request outputs 0, busy_o=0, done_o=0, err_o=0, index/retries/budgets 0, asynchronously, including mid-access.

Configuration
REQ-031 Macro SLV_GUARD_CFG_READBACK_EN defined: after each successful write, state RD_CHECK issues a read (reg_write_o=0) to same address; reg_rdata_i mismatch counts as error per REQ-024 and retries the write.
REQ-032 Macro undefined: RD_CHECK absent, no reads issued, latency per REQ-029.

Verification
REQ-033 NumBudgets=8, budgets 1..8, ready always 1, start_i -> writes 0x04..0x20 data 1..8 then 0x00=0x100, done_o after 19 cycles.
REQ-034 ready delayed 3 cycles per access -> request fields stable throughout, same write order, done_o=1.
REQ-035 reg_error_i=1 on first attempt at 0x0c -> 0x0c rewritten once, sequence completes, err_o=0.
REQ-036 reg_error_i=1 on 3 attempts at 0x10 -> ERROR, err_o=1, enable never written; next start_i clears err_o and restarts.
REQ-037 DONE then rst_req_i=1 -> done_o=0, all 9 writes reissued with stored budgets, done_o=1 again.
REQ-038 rst_ni low during 5th write -> outputs 0 immediately, IDLE; with macro, rdata mismatch on 0x08 -> write reissued.
